spi_lms_top: RTL and testbench

Top-level block of the adaptive-filter design. Receives 14-bit words over a slow SPI-style serial link and runs a sample-by-sample LMS adaptive FIR on them. Each sample pair is a sync word, a reference sample x and a desired sample d. The most recent error e = d − y is returned on miso during every subsequent frame.

---
 rtl/spi_lms_pkg.sv | 38 +++
 rtl/spi_slave_if.sv | 82 ++++++++
 rtl/spi_lms_top.sv | 163 ++++++++++++++++
 tb/tb_spi_lms_top.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/spi_lms_pkg.sv
// Shared parameters, parser state type and saturation helpers for the SPI-fed LMS filter.
package spi_lms_pkg;

    localparam int unsigned DW       = 14;
    localparam int unsigned WW       = 18;
    localparam int unsigned FRAC     = WW - 2;
    localparam int unsigned TAPS     = 4;
    localparam int unsigned MU_SHIFT = 8;
    localparam int unsigned KW       = $clog2(TAPS);
    localparam int unsigned PW       = WW + DW;
    localparam int unsigned AW       = PW + KW;
    localparam int unsigned SW       = 40;
    localparam int unsigned STW      = $clog2(2 * TAPS + 2);

    localparam logic [DW-1:0] SYNC_WORD = 14'h0FFF;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        GET_X = 2'd1,
        GET_D = 2'd2,
        CALC  = 2'd3
    } state_e;

    function automatic logic signed [DW-1:0] sat_dw(input logic signed [SW-1:0] v);
        if (v[SW-1:DW-1] == {(SW-DW+1){v[SW-1]}}) begin
            return v[DW-1:0];
        end
        return v[SW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    endfunction

    function automatic logic signed [WW-1:0] sat_ww(input logic signed [SW-1:0] v);
        if (v[SW-1:WW-1] == {(SW-WW+1){v[SW-1]}}) begin
            return v[WW-1:0];
        end
        return v[SW-1] ? {1'b1, {(WW-1){1'b0}}} : {1'b0, {(WW-1){1'b1}}};
    endfunction

endpackage

// File: rtl/spi_slave_if.sv
// SPI slave front end: input synchronizers, edge detection, 14-bit RX framing and TX shifter.
module spi_slave_if
    import spi_lms_pkg::*;
(
    input  logic          i_clk,
    input  logic          i_rstn,
    input  logic          i_sck,
    input  logic          i_mosi,
    input  logic          i_cs,
    input  logic [DW-1:0] i_tx_word,
    output logic [DW-1:0] o_rx_word,
    output logic          o_frame_vld,
    output logic          o_frame_abort,
    output logic          o_miso
);

    localparam int unsigned CW = $clog2(DW + 2);

    logic [2:0]    r_sck_s;
    logic [2:0]    r_cs_s;
    logic [1:0]    r_mosi_s;
    logic [CW-1:0] r_cnt;
    logic [DW-1:0] r_tx;

    logic w_sck_rise, w_sck_fall, w_cs_fall, w_cs_rise, w_cs_act;

    // Stage [1] is the synchronized level, stage [2] its one-clk-old copy.
    assign w_sck_rise = r_sck_s[1] & ~r_sck_s[2];
    assign w_sck_fall = ~r_sck_s[1] & r_sck_s[2];
    assign w_cs_fall  = ~r_cs_s[1] & r_cs_s[2];
    assign w_cs_rise  = r_cs_s[1] & ~r_cs_s[2];
    assign w_cs_act   = ~r_cs_s[1];
    assign o_miso     = r_tx[DW-1];

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_sck_s  <= '0;
            r_cs_s   <= '1;
            r_mosi_s <= '0;
        end else begin
            r_sck_s  <= {r_sck_s[1:0], i_sck};
            r_cs_s   <= {r_cs_s[1:0], i_cs};
            r_mosi_s <= {r_mosi_s[0], i_mosi};
        end
    end

    // Receive shifter; the bit counter saturates so over-long frames stay invalid.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_cnt         <= '0;
            o_rx_word     <= '0;
            o_frame_vld   <= 1'b0;
            o_frame_abort <= 1'b0;
        end else begin
            o_frame_vld   <= w_cs_rise && (r_cnt == CW'(DW));
            o_frame_abort <= w_cs_rise && (r_cnt != CW'(DW));
            if (w_cs_fall) begin
                r_cnt     <= '0;
                o_rx_word <= '0;
            end else if (w_sck_rise && w_cs_act) begin
                o_rx_word <= {o_rx_word[DW-2:0], r_mosi_s[1]};
                if (r_cnt != '1) begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    end

    // Transmit shifter; its MSB is miso, so clearing it forces miso low between frames.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_tx <= '0;
        end else if (w_cs_fall) begin
            r_tx <= i_tx_word;
        end else if (w_cs_rise) begin
            r_tx <= '0;
        end else if (w_sck_fall && w_cs_act) begin
            r_tx <= {r_tx[DW-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/spi_lms_top.sv
// SPI-fed sample-by-sample LMS adaptive FIR with a single shared multiplier.
// Define LMS_UPDATE_EN to enable weight adaptation; otherwise weights stay at reset values.
module spi_lms_top
    import spi_lms_pkg::*;
(
    input  logic clk,
    input  logic rstn,
    input  logic sck,
    input  logic mosi,
    input  logic cs,
    output logic miso
);

    localparam logic signed [WW-1:0] W_ONE = WW'(1) << FRAC;
    localparam logic [STW-1:0] STEP_E    = STW'(TAPS);
    localparam logic [STW-1:0] STEP_LAST = STW'(2 * TAPS + 1);

    logic [DW-1:0] w_rx_word, w_word;
    logic          w_fv, w_fa, w_word_vld, w_ld_x, w_ld_d;
    state_e        r_state, w_state_nxt;

    logic                 r_pend_vld;
    logic [DW-1:0]        r_pend_word;
    logic signed [DW-1:0] r_x, r_d, r_e, r_e_reg;
    logic signed [DW-1:0] r_xh [TAPS];
    logic signed [WW-1:0] w_w  [TAPS];
    logic signed [AW-1:0] r_acc;
    logic [STW-1:0]       r_step;
    logic [KW-1:0]        w_k;
    logic signed [WW-1:0] w_mul_a;
    logic signed [PW-1:0] w_prod;

    spi_slave_if u_spi (
        .i_clk         (clk),
        .i_rstn        (rstn),
        .i_sck         (sck),
        .i_mosi        (mosi),
        .i_cs          (cs),
        .i_tx_word     (r_e_reg),
        .o_rx_word     (w_rx_word),
        .o_frame_vld   (w_fv),
        .o_frame_abort (w_fa),
        .o_miso        (miso)
    );

    // A word parked during CALC is served first once the parser is free again.
    assign w_word_vld = w_fv | r_pend_vld;
    assign w_word     = r_pend_vld ? r_pend_word : w_rx_word;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= SYNC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ld_x      = 1'b0;
        w_ld_d      = 1'b0;
        case (r_state)
            SYNC: begin
                if (w_word_vld && (w_word == SYNC_WORD)) w_state_nxt = GET_X;
            end
            GET_X: begin
                if (w_word_vld) begin
                    w_ld_x      = 1'b1;
                    w_state_nxt = GET_D;
                end else if (w_fa) begin
                    w_state_nxt = SYNC;
                end
            end
            GET_D: begin
                if (w_word_vld) begin
                    w_ld_d      = 1'b1;
                    w_state_nxt = CALC;
                end else if (w_fa) begin
                    w_state_nxt = SYNC;
                end
            end
            CALC: begin
                if (r_step == STEP_LAST) w_state_nxt = SYNC;
            end
            default: w_state_nxt = SYNC;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pend_vld  <= 1'b0;
            r_pend_word <= '0;
        end else if (r_state == CALC) begin
            if (w_fv) begin
                r_pend_vld  <= 1'b1;
                r_pend_word <= w_rx_word;
            end
        end else begin
            r_pend_vld  <= r_pend_vld & w_fv;
            r_pend_word <= w_rx_word;
        end
    end

    // Tap index: steps 0..TAPS-1 accumulate, TAPS+1..2*TAPS update weights.
    always_comb begin
        w_k = KW'(r_step);
        if (r_step > STEP_E) w_k = KW'(r_step - STW'(TAPS + 1));
    end

`ifdef LMS_UPDATE_EN
    assign w_mul_a = (r_step < STEP_E) ? w_w[w_k] : WW'(r_e);
`else
    assign w_mul_a = w_w[w_k];
`endif
    assign w_prod = PW'(w_mul_a) * PW'(r_xh[w_k]);

`ifdef LMS_UPDATE_EN
    logic signed [WW-1:0] r_w [TAPS];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < TAPS; k++) r_w[k] <= (k == 0) ? W_ONE : '0;
        end else if ((r_state == CALC) && (r_step > STEP_E) && (r_step < STEP_LAST)) begin
            r_w[w_k] <= sat_ww(SW'(r_w[w_k]) + SW'(w_prod >>> MU_SHIFT));
        end
    end

    always_comb begin
        for (int k = 0; k < TAPS; k++) w_w[k] = r_w[k];
    end
`else
    always_comb begin
        for (int k = 0; k < TAPS; k++) w_w[k] = (k == 0) ? W_ONE : '0;
    end
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_x     <= '0;
            r_d     <= '0;
            r_e     <= '0;
            r_e_reg <= '0;
            r_acc   <= '0;
            r_step  <= '0;
            for (int k = 0; k < TAPS; k++) r_xh[k] <= '0;
        end else begin
            if (w_ld_x) r_x <= $signed(w_word);
            if (w_ld_d) begin
                r_d     <= $signed(w_word);
                r_xh[0] <= r_x;
                for (int k = 1; k < TAPS; k++) r_xh[k] <= r_xh[k-1];
                r_acc   <= '0;
                r_step  <= '0;
            end else if (r_state == CALC) begin
                r_step <= r_step + STW'(1);
                if (r_step < STEP_E) r_acc <= r_acc + AW'(w_prod);
                if (r_step == STEP_E) r_e <= sat_dw(SW'(r_d) - SW'(r_acc >>> FRAC));
                if (r_step == STEP_LAST) r_e_reg <= r_e;
            end
        end
    end

endmodule

// File: tb/tb_spi_lms_top.sv
// Directed bench for spi_lms_top: SPI frames in, error word read back on miso.
module tb_spi_lms_top;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic sck = 1'b0;
    logic mosi = 1'b0;
    logic cs = 1'b1;
    logic miso;

    int errors = 0;
    int checks = 0;

    longint mw [4];
    longint mxh [4];

    always #5 clk = ~clk;

    spi_lms_top dut (
        .clk  (clk),
        .rstn (rstn),
        .sck  (sck),
        .mosi (mosi),
        .cs   (cs),
        .miso (miso)
    );

    task automatic check(input string tag, input logic [13:0] obs, input logic [13:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One frame of nbits bits; miso is sampled just before each sck rising edge.
    task automatic xfer(input logic [13:0] w, input int nbits, output logic [13:0] r);
        r = '0;
        cs = 1'b0;
        #80;
        for (int i = 0; i < nbits; i++) begin
            mosi = w[13-i];
            #80;
            r[13-i] = miso;
            sck = 1'b1;
            #80;
            sck = 1'b0;
        end
        #80;
        cs = 1'b1;
        mosi = 1'b0;
        #200;
    endtask

    task automatic send(input logic [13:0] w);
        logic [13:0] dummy;
        xfer(w, 14, dummy);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            mw[k]  = (k == 0) ? 64'sd65536 : 64'sd0;
            mxh[k] = 0;
        end
    endtask

    // Reference LMS step: returns the saturated error for one (x, d) pair.
    task automatic model_pair(input int x, input int d, output int e);
        longint acc, y, v, nw;
        for (int k = 3; k > 0; k--) mxh[k] = mxh[k-1];
        mxh[0] = x;
        acc = 0;
        for (int k = 0; k < 4; k++) acc += mw[k] * mxh[k];
        y = acc >>> 16;
        v = longint'(d) - y;
        e = (v > 8191) ? 8191 : (v < -8192) ? -8192 : int'(v);
`ifdef LMS_UPDATE_EN
        for (int k = 0; k < 4; k++) begin
            nw = mw[k] + ((longint'(e) * mxh[k]) >>> 8);
            mw[k] = (nw > 131071) ? 131071 : (nw < -131072) ? -131072 : nw;
        end
`endif
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        cs = 1'b1;
        sck = 1'b0;
        mosi = 1'b0;
        #100;
        rstn = 1'b1;
        #100;
        model_reset();
    endtask

    initial begin
        logic [13:0] r;
        int e;
        int prev_e;

        do_reset();
        check("reset_miso", {13'd0, miso}, 14'h0000);

        xfer(14'h0000, 14, r);
        check("first_frame", r, 14'h0000);

        send(14'd1355);
        send(14'd1356);
        xfer(14'h0000, 14, r);
        check("no_sync", r, 14'h0000);

        send(14'h0FFF);
        send(14'd1355);
        send(14'd1356);
        model_pair(1355, 1356, e);
        xfer(14'h0000, 14, r);
        check("pair1", r, 14'h0001);
        check("idle_miso", {13'd0, miso}, 14'h0000);

        send(14'h0FFF);
        xfer(14'h2AAA, 7, r);
        send(14'h0FFF);
        send(14'd100);
        send(14'd90);
        model_pair(100, 90, e);
        xfer(14'h0000, 14, r);
        check("abort_then_pair", r, 14'h3FF6);
        xfer(14'h0000, 14, r);
        check("e_hold", r, 14'h3FF6);

        send(14'h0FFF);
        send(14'h2000);
        send(14'h1FFF);
        model_pair(-8192, 8191, e);
        xfer(14'h0000, 14, r);
        check("saturate", r, 14'h1FFF);
        prev_e = e;

        // Stray sck edges with cs high must not disturb framing.
        for (int i = 0; i < 5; i++) begin
            sck = 1'b1;
            #40;
            sck = 1'b0;
            #40;
        end

        for (int n = 0; n < 6; n++) begin
            int x, d;
            x = n * 1000 - 3000;
            d = n * 700 + 11;
            xfer(14'h0FFF, 14, r);
            check($sformatf("sweep_%0d", n), r, 14'(prev_e));
            send(14'(x));
            send(14'(d));
            model_pair(x, d, e);
            prev_e = e;
        end
        xfer(14'h0000, 14, r);
        check("sweep_last", r, 14'(prev_e));

        // Reset in the middle of a frame.
        cs = 1'b0;
        #80;
        for (int i = 0; i < 3; i++) begin
            mosi = 1'b1;
            #80;
            sck = 1'b1;
            #80;
            sck = 1'b0;
        end
        rstn = 1'b0;
        #20;
        check("midframe_reset_miso", {13'd0, miso}, 14'h0000);
        do_reset();
        xfer(14'h0000, 14, r);
        check("after_reset_e", r, 14'h0000);

        send(14'h0FFF);
        send(14'd1355);
        send(14'd1356);
        model_pair(1355, 1356, e);
        xfer(14'h0000, 14, r);
        check("post_reset_pair", r, 14'h0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
